// File: rtl/fsm_counter_pkg.sv
// Shared definitions for the mode counter: FSM state encoding and parameter legality limits.
package fsm_counter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StSat  = 2'b10
    } state_e;

    localparam int unsigned MinWidth    = 2;
    localparam int unsigned MaxWidth    = 32;
    localparam int unsigned MinPrescale = 1;
    localparam int unsigned MaxPrescale = 65535;

    function automatic bit params_legal(int unsigned width, longint unsigned max_val,
                                        int unsigned prescale);
        return (width >= MinWidth) && (width <= MaxWidth) &&
               (max_val >= 64'd1) && (max_val <= ((64'd1 << width) - 64'd1)) &&
               (prescale >= MinPrescale) && (prescale <= MaxPrescale);
    endfunction

endpackage

// File: rtl/count_prescaler.sv
// Enable-gated prescaler: tick marks the PRESCALE-th enabled cycle; restart returns it to zero.
module count_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fsm_mode_counter.sv
// Up/down counter with wrap or saturate boundary handling, prescaled stepping, load and clear.
module fsm_mode_counter
    import fsm_counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int unsigned      PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] num,
    output logic             tc,
    output logic             ovf,
    output logic             saturated
);

    if (!params_legal(WIDTH, 64'(MAX_VAL), PRESCALE)) begin : g_param_check
        $error("fsm_mode_counter: illegal WIDTH/MAX_VAL/PRESCALE");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d, num_next;
    logic             tc_q, tc_d, ovf_q, ovf_d, sat_q;
    logic             step, at_max, at_zero, hit;

    count_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .restart(clr | load),
        .tick   (step)
    );

    assign at_max   = (num_q == MAX_VAL);
    assign at_zero  = (num_q == '0);
    // hit: this step would cross the boundary in the requested direction
    assign hit      = up_dn ? at_max : at_zero;
    assign num_next = up_dn ? (at_max ? '0 : num_q + WIDTH'(1))
                            : (at_zero ? MAX_VAL : num_q - WIDTH'(1));

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = StIdle;
            num_d   = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            state_d = en ? StRun : StIdle;
            num_d   = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else begin
            unique case (state_q)
                StIdle, StRun: state_d = en ? StRun : StIdle;
                StSat:         state_d = StSat;
                default:       state_d = StIdle;
            endcase
            if (step) begin
                if (hit && sat_mode) begin
                    // A toward-boundary step while already saturated is ignored without a tc.
                    if (state_q != StSat) begin
                        state_d = StSat;
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                    end
                end else begin
                    // Covers normal steps, away-from-boundary exits and wraps (also out of SAT
                    // when sat_mode was dropped while saturated).
                    state_d = StRun;
                    num_d   = num_next;
                    if (hit) begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            num_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            sat_q   <= (state_d == StSat);
        end
    end

    assign num       = num_q;
    assign tc        = tc_q;
    assign ovf       = ovf_q;
    assign saturated = sat_q;

endmodule

// File: tb/tb_fsm_mode_counter.sv
// Scoreboard bench: three counter configurations share random stimulus, checked against a model.
module tb_fsm_mode_counter;

    localparam int NDUT = 3;

    typedef struct {
        int num;
        bit tc;
        bit ovf;
        bit sat;
        int pcnt;
    } mdl_t;

    typedef struct {
        int num;
        bit tc;
        bit ovf;
        bit sat;
    } exp_t;

    int maxv [NDUT] = '{7, 5, 11};
    int pre  [NDUT] = '{1, 1, 3};
    int mask [NDUT] = '{7, 15, 15};

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en = 1'b0, up_dn = 1'b1, sat_mode = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [2:0] num0;
    logic [3:0] num1, num2;
    logic [2:0] tc_v, ovf_v, sat_v;

    mdl_t mdl [NDUT];
    exp_t q0[$], q1[$], q2[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fsm_mode_counter #(.WIDTH(3), .MAX_VAL(3'd7), .PRESCALE(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .clr(clr), .load(load), .load_val(load_val[2:0]), .num(num0), .tc(tc_v[0]),
        .ovf(ovf_v[0]), .saturated(sat_v[0])
    );

    fsm_mode_counter #(.WIDTH(4), .MAX_VAL(4'd5), .PRESCALE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .clr(clr), .load(load), .load_val(load_val), .num(num1), .tc(tc_v[1]),
        .ovf(ovf_v[1]), .saturated(sat_v[1])
    );

    fsm_mode_counter #(.WIDTH(4), .MAX_VAL(4'd11), .PRESCALE(3)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .clr(clr), .load(load), .load_val(load_val), .num(num2), .tc(tc_v[2]),
        .ovf(ovf_v[2]), .saturated(sat_v[2])
    );

    function automatic int dut_num(int i);
        case (i)
            0:       return int'(num0);
            1:       return int'(num1);
            default: return int'(num2);
        endcase
    endfunction

    function automatic void cmp(string name, int i, exp_t e);
        int an = dut_num(i);
        checks++;
        if (an != e.num || tc_v[i] !== e.tc || ovf_v[i] !== e.ovf || sat_v[i] !== e.sat) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got num=%0d tc=%b ovf=%b sat=%b, want num=%0d tc=%b ovf=%b sat=%b",
                     name, i, $time, an, tc_v[i], ovf_v[i], sat_v[i], e.num, e.tc, e.ovf, e.sat);
        end
    endfunction

    // Reference behaviour for one clock edge, given the inputs currently applied.
    function automatic void model_cycle(int i);
        int  range = maxv[i] + 1;
        int  lv;
        bit  tick, at_edge;
        mdl[i].tc = 1'b0;
        if (clr) begin
            mdl[i].num  = 0;
            mdl[i].ovf  = 1'b0;
            mdl[i].sat  = 1'b0;
            mdl[i].pcnt = 0;
        end else if (load) begin
            lv          = int'(load_val) & mask[i];
            mdl[i].num  = (lv > maxv[i]) ? maxv[i] : lv;
            mdl[i].sat  = 1'b0;
            mdl[i].pcnt = 0;
        end else if (en) begin
            tick        = (mdl[i].pcnt == pre[i] - 1);
            mdl[i].pcnt = tick ? 0 : mdl[i].pcnt + 1;
            if (tick) begin
                at_edge = up_dn ? (mdl[i].num == maxv[i]) : (mdl[i].num == 0);
                if (at_edge && sat_mode) begin
                    if (!mdl[i].sat) begin
                        mdl[i].sat = 1'b1;
                        mdl[i].tc  = 1'b1;
                        mdl[i].ovf = 1'b1;
                    end
                end else begin
                    mdl[i].num = (mdl[i].num + (up_dn ? 1 : range - 1)) % range;
                    mdl[i].sat = 1'b0;
                    if (at_edge) begin
                        mdl[i].tc  = 1'b1;
                        mdl[i].ovf = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic drive(bit e, bit u, bit s, bit c, bit l, logic [3:0] lv);
        exp_t x;
        @(negedge clk);
        #1;
        en = e; up_dn = u; sat_mode = s; clr = c; load = l; load_val = lv;
        for (int i = 0; i < NDUT; i++) begin
            model_cycle(i);
            x.num = mdl[i].num; x.tc = mdl[i].tc; x.ovf = mdl[i].ovf; x.sat = mdl[i].sat;
            case (i)
                0:       q0.push_back(x);
                1:       q1.push_back(x);
                default: q2.push_back(x);
            endcase
        end
    endtask

    // Asserts reset between edges and checks that outputs clear without waiting for a clock.
    task automatic pulse_reset();
        exp_t z;
        z.num = 0; z.tc = 1'b0; z.ovf = 1'b0; z.sat = 1'b0;
        reset_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            cmp("async_reset", i, z);
            mdl[i].num = 0; mdl[i].tc = 1'b0; mdl[i].ovf = 1'b0;
            mdl[i].sat = 1'b0; mdl[i].pcnt = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin e = q0.pop_front(); cmp("scoreboard", 0, e); end
            if (q1.size() > 0) begin e = q1.pop_front(); cmp("scoreboard", 1, e); end
            if (q2.size() > 0) begin e = q2.pop_front(); cmp("scoreboard", 2, e); end
        end
    end

    initial begin : stimulus
        bit u, s;
        #2;
        pulse_reset();

        // Wrap up through the top, then wrap down from zero, then clear.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Saturate up, linger in SAT, then step back down out of it.
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // Prescaler holds across a disabled cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // Clamped load with a simultaneous step, then load together with clear.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9);

        // Count to 4, then reset mid-cycle.
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        #3;
        pulse_reset();

        u = 1'b1;
        s = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 9) == 0) u = ~u;
            if ($urandom_range(0, 24) == 0) s = ~s;
            if ($urandom_range(0, 149) == 0) begin
                @(negedge clk);
                #3;
                pulse_reset();
            end else begin
                drive(($urandom_range(0, 3) != 0), u, s, ($urandom_range(0, 39) == 0),
                      ($urandom_range(0, 29) == 0), 4'($urandom_range(0, 15)));
            end
        end

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_mode_counter.md
FSM_MODE_COUNTER -- requirements
Module: fsm_mode_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and reset_n.
REQ-002 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-003 Parameter MAX_VAL, default 2**WIDTH-1: top of count range; count range is 0..MAX_VAL; legal range 1..2**WIDTH-1.
REQ-004 Parameter PRESCALE, default 1: number of enabled cycles per count step; legal range 1..65535.
REQ-005 Port clk  in  1  rising-edge clock.
REQ-006 Port reset_n  in  1  asynchronous active-low reset.
REQ-007 Port en  in  1  count enable; when low, count and prescaler hold.
REQ-008 Port up_dn  in  1  direction: 1 counts up, 0 counts down.
REQ-009 Port sat_mode  in  1  boundary mode: 1 saturates at the boundary, 0 wraps.
REQ-010 Port clr  in  1  synchronous clear.
REQ-011 Port load  in  1  synchronous load strobe.
REQ-012 Port load_val  in  WIDTH  value to load.
REQ-013 Port num  out  WIDTH  current count, registered.
REQ-014 Port tc  out  1  terminal-count pulse, registered, one cycle.
REQ-015 Port ovf  out  1  sticky boundary-event flag.
REQ-016 Port saturated  out  1  high while the FSM is in SAT.

Function
REQ-017 The FSM SHALL have 3 states: IDLE, RUN, SAT; the state encoding is a package constant.
REQ-018 Transitions SHALL be: IDLE->RUN when en=1; RUN->IDLE when en=0; RUN->SAT on a saturating boundary step; SAT->RUN on a step request whose direction moves away from the held boundary; any state->IDLE on clr; any state->RUN on load with en=1, else ->IDLE.
REQ-019 A step request SHALL be defined as en=1 and prescaler tick=1; with PRESCALE=1 every enabled cycle is a step request.
REQ-020 The prescaler SHALL advance only when en=1, SHALL hold when en=0, and SHALL return to zero on clr or load.
REQ-021 Input priority SHALL be: clr > load > step.
REQ-022 clr SHALL set num=0, ovf=0, tc=0, and clear the prescaler on the next edge.
REQ-023 load SHALL set num=min(load_val, MAX_VAL) on the next edge and SHALL NOT assert tc or ovf.
REQ-024 On a step in IDLE or RUN, num SHALL change on the same edge that samples the request (latency 1 cycle from en/tick to num).
REQ-025 Up step: num<MAX_VAL gives num+1; num=MAX_VAL gives 0 in wrap mode, or holds at MAX_VAL and enters SAT in saturate mode.
REQ-026 Down step: num>0 gives num-1; num=0 gives MAX_VAL in wrap mode, or holds at 0 and enters SAT in saturate mode.
REQ-027 A step in SAT toward the held boundary SHALL be ignored; a step away from it SHALL move num by 1 and return to RUN.
REQ-028 tc SHALL pulse high for exactly one cycle after each wrap step or each step that enters SAT; repeated ignored steps in SAT SHALL NOT re-pulse tc.
REQ-029 ovf SHALL set together with tc and SHALL remain set until clr or reset.
REQ-030 A change of sat_mode while in SAT SHALL take effect on the next step request only.
REQ-031 A load_val greater than MAX_VAL SHALL clamp to MAX_VAL.

Reset
REQ-032 Assertion of reset_n=0 SHALL immediately force state=IDLE, num=0, tc=0, ovf=0, saturated=0, and prescaler=0, independent of clk.
REQ-033 Reset asserted mid-count SHALL discard any pending step; the first step after deassertion SHALL require a full PRESCALE enabled cycles.

Structure
REQ-034 State encoding and parameter-legality constants SHALL live in the shared package fsm_counter_pkg.
REQ-035 The prescaler SHALL be a sub-module count_prescaler (parameter PRESCALE; inputs clk, reset_n, en, restart; output tick).
REQ-036 All outputs SHALL be driven directly from flops.

Verification
REQ-037 Set WIDTH=3, MAX_VAL=7, wrap, up, en=1 for 8 cycles from 0 -> num 1..7 then 0, tc one pulse after 7->0, ovf=1.
REQ-038 Set WIDTH=3, wrap, down, en=1 from 0 -> num=7, tc pulse, ovf=1; then clr -> num=0, ovf=0.
REQ-039 Set MAX_VAL=5, sat_mode=1, up, 8 steps -> num stops at 5, saturated=1, a single tc pulse; then up_dn=0 -> num=4, saturated=0.
REQ-040 Set PRESCALE=3 with en pattern 1,1,0,1 -> num increments only on the 3rd enabled edge; the en=0 cycle holds the prescaler.
REQ-041 Set MAX_VAL=5, load=1 with load_val=9 and a simultaneous step -> num=5, no tc; load together with clr -> num=0.
REQ-042 Assert reset_n mid-count at num=4 between clock edges -> num=0 and ovf=0 immediately, FSM in IDLE.
